// File: rtl/control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_unit : fetch / wait / decode / execute sequencer with ARM-style   |
// |   condition evaluation and a {N,Z,C,V} status register.                  |
// | Optional macro CU_MOC_TIMEOUT_EN bounds WAIT and adds a sticky FAULT.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module control_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        mem_moc,
    input  logic [31:0] ir_in,
    input  logic [3:0]  alu_flags,
    output logic        mar_ld,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        mfa,
    output logic        reg_en,
    output logic [3:0]  flags,
    output logic [2:0]  state,
    output logic        fault
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_WAIT   = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_FAULT  = 3'd7;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_run;
    logic [31:0] r_ir;
    logic        r_cond_pass;
    logic [3:0]  r_flags;
    logic        w_cond;
    logic        w_timeout;
    logic        w_fetch;
    logic        w_wait;
    logic        w_exec;
    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;

    // r_run holds strobes off until the first edge after reset release.
    assign w_fetch = r_run && (r_state == c_FETCH);
    assign w_wait  = (r_state == c_WAIT);
    assign w_exec  = (r_state == c_EXEC);

    assign mar_ld = w_fetch;
    assign mfa    = w_fetch | w_wait;
    assign ir_ld  = w_wait & mem_moc;
    assign pc_inc = w_wait & mem_moc;
    assign reg_en = w_exec & r_cond_pass;
    assign flags  = r_flags;
    assign state  = r_state;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        w_cond = 1'b0;
        case (r_ir[31:28])
            4'h0:    w_cond = w_z;
            4'h1:    w_cond = ~w_z;
            4'h2:    w_cond = w_c;
            4'h3:    w_cond = ~w_c;
            4'h4:    w_cond = w_n;
            4'h5:    w_cond = ~w_n;
            4'h6:    w_cond = w_v;
            4'h7:    w_cond = ~w_v;
            4'h8:    w_cond = w_c & ~w_z;
            4'h9:    w_cond = ~w_c | w_z;
            4'hA:    w_cond = (w_n == w_v);
            4'hB:    w_cond = (w_n != w_v);
            4'hC:    w_cond = ~w_z & (w_n == w_v);
            4'hD:    w_cond = w_z | (w_n != w_v);
            4'hE:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

`ifdef CU_MOC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_tcnt;

    assign w_timeout = (r_tcnt == CW'(TIMEOUT - 1));
    assign fault     = (r_state == c_FAULT);

    // Cleared in FETCH so every WAIT starts counting from zero.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_tcnt <= '0;
        end else if (r_state == c_FETCH) begin
            r_tcnt <= '0;
        end else if (w_wait && !mem_moc && !w_timeout) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        w_next = c_FETCH;
        if (r_run) begin
            case (r_state)
                c_FETCH:  w_next = c_WAIT;
                c_WAIT: begin
                    if (mem_moc)        w_next = c_DECODE;
                    else if (w_timeout) w_next = c_FAULT;
                    else                w_next = c_WAIT;
                end
                c_DECODE: w_next = c_EXEC;
                c_EXEC:   w_next = c_FETCH;
`ifdef CU_MOC_TIMEOUT_EN
                c_FAULT:  w_next = c_FAULT;
`endif
                default:  w_next = c_FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_run       <= 1'b0;
            r_state     <= c_FETCH;
            r_ir        <= '0;
            r_cond_pass <= 1'b0;
            r_flags     <= 4'b0000;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (ir_ld) begin
                r_ir <= ir_in;
            end
            if (r_state == c_DECODE) begin
                r_cond_pass <= w_cond;
            end
            if (reg_en && r_ir[20]) begin
                r_flags <= alu_flags;
            end
        end
    end

    // Only the condition field and S bit steer control; the rest is kept for completeness.
    logic w_unused_ir;
    assign w_unused_ir = ^{r_ir[27:21], r_ir[19:0]};

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum cycles spent waiting for mem_moc before a fetch faults (only used under REQ-030).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clr  input  1  asynchronous, active-low reset.
REQ-004 mem_moc  input  1  memory operation complete; high for at least one cycle when fetch data is valid.
REQ-005 ir_in  input  32  instruction word from memory, sampled when ir_ld is high.
REQ-006 alu_flags  input  4  {N,Z,C,V} produced by the datapath ALU in the current cycle.
REQ-007 mar_ld, ir_ld, pc_inc  output  1 each  datapath load/increment strobes.
REQ-008 mfa  output  1  memory function activate (read request).
REQ-009 reg_en  output  1  register-file write enable for the executing instruction.
REQ-010 flags  output  4  status register {N,Z,C,V}; flags[1] drives the datapath carry-in.
REQ-011 state  output  3  current FSM state encoding, for debug.
REQ-012 fault  output  1  high while in FAULT.

Function
REQ-013 FSM states and encodings: FETCH=3'd0, WAIT=3'd1, DECODE=3'd2, EXEC=3'd3, FAULT=3'd7; others unreachable and map to FETCH on the next edge.
REQ-014 FETCH: mar_ld=1 and mfa=1 for exactly one cycle; next state is WAIT.
REQ-015 WAIT: mfa held at 1; when mem_moc=1, ir_ld=1 and pc_inc=1 in that same cycle and the next state is DECODE; otherwise the FSM stays in WAIT.
REQ-016 Internal IR register captures ir_in on the edge ending a cycle with ir_ld=1.
REQ-017 DECODE: evaluates cond=IR[31:28] against flags using ARM rules: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 4'b1111 evaluates as fail. The result is registered as cond_pass; next state is EXEC.
REQ-018 EXEC: reg_en=cond_pass for exactly one cycle; next state is FETCH.
REQ-019 Status update occurs at the end of EXEC when cond_pass=1 and S bit IR[20]=1: flags<=alu_flags.
REQ-020 Flags are held unchanged in all other cases.
REQ-021 Throughput: 4 cycles per instruction when mem_moc is already high in the first WAIT cycle; each additional WAIT cycle adds exactly 1.
REQ-022 All strobes (mar_ld, ir_ld, pc_inc, mfa, reg_en) are zero in any state or cycle not listed above; strobes are Moore-decoded from state, except ir_ld/pc_inc which are also gated by mem_moc.
REQ-023 mem_moc asserted outside WAIT is ignored.
REQ-024 In WAIT, mem_moc held high for several cycles produces only one ir_ld/pc_inc pulse, because the state leaves WAIT after that cycle.

Reset
REQ-025 Clr=0 forces the following asynchronously, including mid-WAIT or mid-EXEC: state=FETCH, IR=0, cond_pass=0, flags=4'b0000, timeout counter=0, and all strobes and fault=0.
REQ-026 The first FETCH begins on the first rising Clk edge after Clr deasserts.
REQ-027 An instruction interrupted by reset shall neither write the register file nor update flags.

Configuration
REQ-028 Macro CU_MOC_TIMEOUT_EN controls the fetch timeout.
REQ-029 Without CU_MOC_TIMEOUT_EN: WAIT has no time bound, FAULT is unreachable, and fault is tied to 0.
REQ-030 With CU_MOC_TIMEOUT_EN: a counter clears on entry to WAIT and increments each WAIT cycle without mem_moc. When it reaches TIMEOUT, the next state is FAULT, with mfa deasserted in FAULT. FAULT is exited only by reset. mem_moc arriving in the same cycle the count reaches TIMEOUT wins, and the FSM goes to DECODE.

Verification
REQ-031 Reset release, mem_moc tied high, ir_in=32'hE0900001 (ADDS, AL) -> state sequence 0,1,2,3,0; reg_en high in cycle 4 only; flags=alu_flags after cycle 4.
REQ-032 flags=4'b0100 (Z set), ir_in=32'h10811002 (ADDNE) -> reg_en stays 0 in EXEC; flags unchanged.
REQ-033 mem_moc delayed 5 cycles -> WAIT lasts 6 cycles; mfa high throughout; single ir_ld/pc_inc pulse; total instruction time 9 cycles.
REQ-034 Clr pulsed low during EXEC with S=1 -> no reg_en pulse; flags=0; state=FETCH immediately.
REQ-035 cond=4'b1111 with every flags value -> reg_en=0 and no flag update.
REQ-036 With CU_MOC_TIMEOUT_EN and TIMEOUT=16, mem_moc never asserted -> FAULT entered after 16 WAIT cycles, fault=1, mfa=0; FSM stays in FAULT until Clr.
